lut_ctrl: RTL and testbench
===========================

# lut_ctrl

Owns the processor's immediate lookup tables (one 32×8 table per `LUT_TYPE`) and shares their single access port between the decode stage (reads) and a byte-stream loader (run-time reprogramming). Decode issues `{type, imm}` and gets the 8-bit value one cycle later. The loader rewrites a whole table in order without halting the core. Decode reads always win the port. After reset, all tables hold the package defaults.

## Interface
Parameters:
- `DEPTH`, 32, entries per table; `imm` width is `$clog2(DEPTH)`.
- `WIDTH`, 8, entry width in bits.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rd_req`  in  1  decode read request, single-cycle qualifier.
- `rd_type`  in  3  `LUT_TYPE` selecting the table.
- `rd_idx`  in  5  entry index (instruction immediate).
- `rd_valid`  out  1  read result valid.
- `rd_data`  out  8  read result.
- `rd_err`  out  1  the request carried `rd_type` ≥ 4.
- `cfg_start`  in  1  begin loading table `cfg_type`.
- `cfg_type`  in  3  table to load, sampled with `cfg_start`.
- `cfg_valid`  in  1  loader byte valid.
- `cfg_data`  in  8  loader byte.
- `cfg_ready`  out  1  byte accepted this cycle when high with `cfg_valid`.
- `cfg_busy`  out  1  load in progress.
- `cfg_done`  out  1  one-cycle pulse after the last byte is written.

## Operation
- Storage: 4×DEPTH×WIDTH registers with one access per cycle, either a read or a write.
- Reads:
  - A read is served in every cycle that `rd_req`=1, regardless of FSM state.
  - `rd_type` ≥ 4 gives `rd_data`=0 and `rd_err`=1.
  - During a load, a read of the table being loaded returns its current contents, which may be partially updated.
- FSM states are IDLE and LOAD.
  - IDLE → LOAD on `cfg_start`=1 with `cfg_type` < 4. This latches the type and clears the 5-bit word counter.
  - `cfg_start` with `cfg_type` ≥ 4 is ignored. `cfg_start` while in LOAD is ignored.
  - In LOAD, `cfg_ready` = !`rd_req`. A byte accepted with `cfg_valid`&&`cfg_ready` is written to entry `counter`, and the counter increments.
  - Accepting entry DEPTH-1 returns the FSM to IDLE and pulses `cfg_done` on the next cycle. The counter does not wrap into a second pass.
- In IDLE, `cfg_ready`=0. `cfg_busy`=1 exactly while in LOAD.
- Reset values: all outputs are 0, FSM is IDLE, counter is 0, tables hold `kLutDefault`.
- Reset asserted mid-load aborts the load and restores every table to defaults, including entries already rewritten.

## Timing
- Read latency is 1 cycle. `rd_req` in cycle N gives `rd_valid`, `rd_data` and `rd_err` registered in cycle N+1.
- `rd_valid` is low in every cycle that follows a cycle with no request. Back-to-back requests give back-to-back results.
- Write visibility: a byte accepted in cycle N is returned by a read issued in cycle N+1 or later.
- `cfg_ready` is combinational from `rd_req` and the FSM state. The loader holds `cfg_data` until accepted.
- Load duration is a minimum of DEPTH cycles from the first accepted byte. Each cycle with `rd_req` high adds one cycle.
- `cfg_start` is accepted in the same cycle that `cfg_done` pulses, because the FSM is already in IDLE.

## Configuration
- `LUT_CTRL_LOAD_EN` defined:
  - The loader FSM, the counter and all `cfg_*` behaviour are as described above.
- `LUT_CTRL_LOAD_EN` undefined:
  - The tables are constant `kLutDefault` (a ROM).
  - `cfg_ready`, `cfg_busy` and `cfg_done` are tied to 0, and the `cfg_*` inputs are ignored.
  - The read path and its latency are unchanged.

## Structure
- Package `LUT_def` holds:
  - `LUT_TYPE` (LUT_SW, LUT_BNE, LUT_LW, LUT_STP).
  - `LUT_NUM`=4 and `LUT_DEPTH`=32.
  - `kLutDefault[4][32]` with these non-zero entries; all other entries are 0:
    - SW: entries 0..7 = 1..8.
    - BNE: entry 0 = 176, entry 1 = 7.
    - LW: entry 0 = 99.
    - STP: all 0.
- One sub-module, `lut_store`: the register array, with reset-to-default, one write port and a registered read port.
- `lut_ctrl` contains the FSM, the arbitration and the error check.

## Test plan
- After reset, read (SW, 3), then (BNE, 0), then (LW, 0) back-to-back → `rd_data` = 4, 176, 99 on consecutive cycles with `rd_valid`=1; (STP, 31) → 0.
- Read with `rd_type`=5, `rd_idx`=0 → next cycle `rd_valid`=1, `rd_err`=1, `rd_data`=0.
- `cfg_start` with type=BNE, then 32 bytes 0x20..0x3F streamed with no reads → `cfg_done` pulses one cycle after the 32nd byte; reads of (BNE, 0) and (BNE, 31) → 0x20 and 0x3F; (SW, 0) still 1.
- Load LW while `rd_req` is held high for 5 cycles mid-stream → `cfg_ready`=0 during those cycles, no byte lost or duplicated, done after 37 cycles, entry k equals byte k.
- Reset after 10 bytes of a SW load → `cfg_busy`=0; (SW, 0) reads 1 again; a new `cfg_start` is accepted.
- `LUT_CTRL_LOAD_EN` undefined: `cfg_start` followed by a full byte stream → `cfg_ready` stays 0, and the tables still return the defaults.

Source files
------------

// File: rtl/lut_ctrl_pkg.sv
`default_nettype none
//============================================================================
// Package : LUT_def
// Desc    : Immediate lookup-table types, sizes and power-on default contents
//           shared by lut_ctrl, lut_store and lut_ctrl_if.
// Rev     : 1.0  initial release
//============================================================================
package LUT_def;

    typedef enum logic [2:0] {
        LUT_SW  = 3'd0,
        LUT_BNE = 3'd1,
        LUT_LW  = 3'd2,
        LUT_STP = 3'd3
    } LUT_TYPE;

    localparam int LUT_NUM   = 4;
    localparam int LUT_DEPTH = 32;
    localparam int LUT_WIDTH = 8;

    typedef logic [LUT_NUM-1:0][LUT_DEPTH-1:0][LUT_WIDTH-1:0] lut_tbl_t;

    // Builds the default image; every entry not listed here is zero.
    function automatic lut_tbl_t build_lut_default();
        lut_tbl_t t;
        t = '0;
        for (int i = 0; i < 8; i++) begin
            t[int'(LUT_SW)][i] = 8'(i + 1);
        end
        t[int'(LUT_BNE)][0] = 8'd176;
        t[int'(LUT_BNE)][1] = 8'd7;
        t[int'(LUT_LW)][0]  = 8'd99;
        return t;
    endfunction

    localparam lut_tbl_t kLutDefault = build_lut_default();

endpackage
`default_nettype wire

// File: rtl/lut_ctrl_if.sv
`default_nettype none
//============================================================================
// Interface : lut_ctrl_if
// Desc      : Decode read port and byte-stream loader port of lut_ctrl.
//             master = decode/loader side, slave = lut_ctrl.
// Rev       : 1.0  initial release
//============================================================================
interface lut_ctrl_if
    import LUT_def::*;
#(
    parameter int DEPTH = LUT_DEPTH,
    parameter int WIDTH = LUT_WIDTH
) ();
    localparam int IDX_W = $clog2(DEPTH);

    logic             rd_req;
    logic [2:0]       rd_type;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             rd_err;

    logic             cfg_start;
    logic [2:0]       cfg_type;
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_data;
    logic             cfg_ready;
    logic             cfg_busy;
    logic             cfg_done;

    modport master (
        output rd_req, rd_type, rd_idx,
        input  rd_valid, rd_data, rd_err,
        output cfg_start, cfg_type, cfg_valid, cfg_data,
        input  cfg_ready, cfg_busy, cfg_done
    );

    modport slave (
        input  rd_req, rd_type, rd_idx,
        output rd_valid, rd_data, rd_err,
        input  cfg_start, cfg_type, cfg_valid, cfg_data,
        output cfg_ready, cfg_busy, cfg_done
    );
endinterface
`default_nettype wire

// File: rtl/lut_ctrl_store.sv
`default_nettype none
//============================================================================
// Module : lut_store
// Desc   : LUT_NUM x DEPTH x WIDTH table storage. Resets to kLutDefault,
//          one write port, one registered read port. With WRITE_EN = 0 the
//          storage collapses to the constant default image (ROM).
// Rev    : 1.0  initial release
//============================================================================
module lut_store
    import LUT_def::*;
#(
    parameter int DEPTH    = LUT_DEPTH,
    parameter int WIDTH    = LUT_WIDTH,
    parameter bit WRITE_EN = 1'b1
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       we,
    input  wire logic [$clog2(LUT_NUM)-1:0] wr_tbl,
    input  wire logic [$clog2(DEPTH)-1:0]   wr_idx,
    input  wire logic [WIDTH-1:0]           wr_data,
    input  wire logic                       rd_en,
    input  wire logic                       rd_zero,
    input  wire logic [$clog2(LUT_NUM)-1:0] rd_tbl,
    input  wire logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [WIDTH-1:0]                rd_data
);

    logic [WIDTH-1:0] w_rd_word;
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    generate
        if (WRITE_EN) begin : g_ram
            logic [LUT_NUM-1:0][DEPTH-1:0][WIDTH-1:0] mem_q;
            logic [LUT_NUM-1:0][DEPTH-1:0][WIDTH-1:0] mem_d;

            // Next table image: a single entry replaced on write.
            always_comb begin
                mem_d = mem_q;
                if (we) begin
                    mem_d[wr_tbl][wr_idx] = wr_data;
                end
            end

            // Table registers; reset restores the full default image.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    mem_q <= kLutDefault;
                end else begin
                    mem_q <= mem_d;
                end
            end

            assign w_rd_word = mem_q[rd_tbl][rd_idx];
        end else begin : g_rom
            logic w_unused_wr;
            assign w_unused_wr = ^{we, wr_tbl, wr_idx, wr_data};
            assign w_rd_word   = kLutDefault[rd_tbl][rd_idx];
        end
    endgenerate

    // Read data register: loads on request, zeroed for an invalid table.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = rd_zero ? '0 : w_rd_word;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/lut_ctrl.sv
`default_nettype none
//============================================================================
// Module : lut_ctrl
// Desc   : Immediate lookup-table controller. Shares a single table access
//          port between decode reads (always win) and a byte-stream loader
//          that rewrites one whole table in order.
//          Build option: LUT_CTRL_LOAD_EN enables the loader; without it the
//          tables are a constant ROM and cfg_* outputs are tied low.
// Rev    : 1.0  initial release
//============================================================================
module lut_ctrl
    import LUT_def::*;
#(
    parameter int DEPTH = LUT_DEPTH,
    parameter int WIDTH = LUT_WIDTH
) (
    input  wire logic clk,
    input  wire logic rst_n,
    lut_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TBL_W = $clog2(LUT_NUM);

    logic             w_rd_err;
    logic             w_we;
    logic [TBL_W-1:0] w_wr_tbl;
    logic [IDX_W-1:0] w_wr_idx;
    logic [WIDTH-1:0] w_wr_data;

    logic rd_valid_q;
    logic rd_valid_d;
    logic rd_err_q;
    logic rd_err_d;

    // Only types 0..3 exist; anything with bit 2 set is out of range.
    assign w_rd_err = bus.rd_type[2];

`ifdef LUT_CTRL_LOAD_EN
    localparam bit c_write_en = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] cnt_d;
    logic [TBL_W-1:0] type_q;
    logic [TBL_W-1:0] type_d;
    logic             done_q;
    logic             done_d;
    logic             w_ready;
    logic             w_accept;

    // Decode reads own the port, so the loader only gets idle read cycles.
    assign w_ready  = (state_q == ST_LOAD) && !bus.rd_req;
    assign w_accept = w_ready && bus.cfg_valid;

    // Loader next-state: start latches type, each accepted byte advances.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_start && !bus.cfg_type[2]) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    type_d  = bus.cfg_type[TBL_W-1:0];
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Loader FSM registers, including the registered done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            type_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
            done_q  <= done_d;
        end
    end

    assign w_we          = w_accept;
    assign w_wr_tbl      = type_q;
    assign w_wr_idx      = cnt_q;
    assign w_wr_data     = bus.cfg_data;
    assign bus.cfg_ready = w_ready;
    assign bus.cfg_busy  = (state_q == ST_LOAD);
    assign bus.cfg_done  = done_q;
`else
    localparam bit c_write_en = 1'b0;

    logic w_unused_cfg;
    assign w_unused_cfg  = ^{bus.cfg_start, bus.cfg_type, bus.cfg_valid, bus.cfg_data};

    assign w_we          = 1'b0;
    assign w_wr_tbl      = '0;
    assign w_wr_idx      = '0;
    assign w_wr_data     = '0;
    assign bus.cfg_ready = 1'b0;
    assign bus.cfg_busy  = 1'b0;
    assign bus.cfg_done  = 1'b0;
`endif

    lut_store #(
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .WRITE_EN (c_write_en)
    ) u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (w_we),
        .wr_tbl  (w_wr_tbl),
        .wr_idx  (w_wr_idx),
        .wr_data (w_wr_data),
        .rd_en   (bus.rd_req),
        .rd_zero (w_rd_err),
        .rd_tbl  (bus.rd_type[TBL_W-1:0]),
        .rd_idx  (bus.rd_idx),
        .rd_data (bus.rd_data)
    );

    // Read qualifiers track the request one cycle later.
    always_comb begin
        rd_valid_d = bus.rd_req;
        rd_err_d   = bus.rd_req && w_rd_err;
    end

    // Read status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_err   = rd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lut_ctrl.sv
`default_nettype none
//============================================================================
// Module : tb_lut_ctrl
// Desc   : Self-checking bench for lut_ctrl: table-driven read vectors plus
//          hand-written loader sequences (LUT_CTRL_LOAD_EN) or ROM checks.
// Rev    : 1.0  initial release
//============================================================================
module tb_lut_ctrl;
    import LUT_def::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lut_ctrl_if bus ();

    lut_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       req;
        logic [2:0] typ;
        logic [4:0] idx;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rd_req    = 1'b0;
        bus.rd_type   = 3'd0;
        bus.rd_idx    = 5'd0;
        bus.cfg_start = 1'b0;
        bus.cfg_type  = 3'd0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = 8'd0;
    endtask

    task automatic rd(input logic [2:0] typ, input logic [4:0] idx, input logic [7:0] exp, input string name);
        bus.rd_req  = 1'b1;
        bus.rd_type = typ;
        bus.rd_idx  = idx;
        tick();
        bus.rd_req  = 1'b0;
        chk({name, "_valid"}, bus.rd_valid, 1);
        chk({name, "_data"}, bus.rd_data, exp);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

`ifdef LUT_CTRL_LOAD_EN
    // Streams 32 bytes base+k into table typ, holding rd_req high for
    // stall_len cycles starting at loop cycle stall_at.
    task automatic load(input logic [2:0] typ, input logic [7:0] base, input int stall_at, input int stall_len);
        int k;
        int cyc;
        int bad_ready;
        k = 0;
        cyc = 0;
        bad_ready = 0;
        bus.cfg_start = 1'b1;
        bus.cfg_type  = typ;
        tick();
        bus.cfg_start = 1'b0;
        chk("busy_after_start", bus.cfg_busy, 1);
        while (k < 32 && cyc < 200) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_data  = base + 8'(k);
            bus.rd_req    = (cyc >= stall_at) && (cyc < stall_at + stall_len);
            bus.rd_type   = typ;
            bus.rd_idx    = 5'd0;
            #1;
            if (bus.rd_req && bus.cfg_ready) bad_ready++;
            if (bus.cfg_ready) k++;
            tick();
            cyc++;
        end
        bus.cfg_valid = 1'b0;
        bus.rd_req    = 1'b0;
        chk("load_bytes", k, 32);
        chk("load_cycles", cyc, 32 + stall_len);
        chk("ready_while_read", bad_ready, 0);
        chk("done_pulse", bus.cfg_done, 1);
        chk("busy_after_done", bus.cfg_busy, 0);
        tick();
        chk("done_one_cycle", bus.cfg_done, 0);
    endtask
`endif

    initial begin
        vt[0]  = '{1'b1, 3'd0, 5'd3,  1'b1, 8'd4,   1'b0};
        vt[1]  = '{1'b1, 3'd1, 5'd0,  1'b1, 8'd176, 1'b0};
        vt[2]  = '{1'b1, 3'd2, 5'd0,  1'b1, 8'd99,  1'b0};
        vt[3]  = '{1'b1, 3'd3, 5'd31, 1'b1, 8'd0,   1'b0};
        vt[4]  = '{1'b1, 3'd5, 5'd0,  1'b1, 8'd0,   1'b1};
        vt[5]  = '{1'b0, 3'd0, 5'd3,  1'b0, 8'd0,   1'b0};
        vt[6]  = '{1'b1, 3'd0, 5'd7,  1'b1, 8'd8,   1'b0};
        vt[7]  = '{1'b1, 3'd0, 5'd8,  1'b1, 8'd0,   1'b0};
        vt[8]  = '{1'b1, 3'd1, 5'd1,  1'b1, 8'd7,   1'b0};
        vt[9]  = '{1'b1, 3'd7, 5'd31, 1'b1, 8'd0,   1'b1};
        vt[10] = '{1'b1, 3'd0, 5'd0,  1'b1, 8'd1,   1'b0};
        vt[11] = '{1'b1, 3'd4, 5'd3,  1'b1, 8'd0,   1'b1};

        do_reset();

        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_rd_err", bus.rd_err, 0);
        chk("rst_cfg_ready", bus.cfg_ready, 0);
        chk("rst_cfg_busy", bus.cfg_busy, 0);
        chk("rst_cfg_done", bus.cfg_done, 0);

        // Back-to-back vectors: each result is visible after the next edge.
        for (int i = 0; i < 12; i++) begin
            bus.rd_req  = vt[i].req;
            bus.rd_type = vt[i].typ;
            bus.rd_idx  = vt[i].idx;
            tick();
            chk($sformatf("vec%0d_valid", i), bus.rd_valid, vt[i].exp_valid);
            if (vt[i].exp_valid) begin
                chk($sformatf("vec%0d_data", i), bus.rd_data, vt[i].exp_data);
            end
            chk($sformatf("vec%0d_err", i), bus.rd_err, vt[i].exp_err);
        end
        idle_inputs();
        tick();
        chk("idle_rd_valid", bus.rd_valid, 0);

`ifdef LUT_CTRL_LOAD_EN
        // Invalid load type is ignored.
        bus.cfg_start = 1'b1;
        bus.cfg_type  = 3'd6;
        tick();
        bus.cfg_start = 1'b0;
        chk("bad_type_busy", bus.cfg_busy, 0);

        // BNE load, no reads.
        load(3'd1, 8'h20, 1000, 0);
        rd(3'd1, 5'd0,  8'h20, "bne0");
        rd(3'd1, 5'd31, 8'h3F, "bne31");
        rd(3'd0, 5'd0,  8'd1,  "sw0_kept");

        // LW load with 5 read stall cycles mid-stream.
        load(3'd2, 8'h40, 10, 5);
        for (int k = 0; k < 32; k++) begin
            rd(3'd2, 5'(k), 8'h40 + 8'(k), $sformatf("lw%0d", k));
        end

        // Reset after 10 accepted bytes of a SW load.
        bus.cfg_start = 1'b1;
        bus.cfg_type  = 3'd0;
        tick();
        bus.cfg_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_data  = 8'hA0 + 8'(k);
            tick();
        end
        bus.cfg_valid = 1'b0;
        rd(3'd0, 5'd2, 8'hA2, "sw2_partial");
        do_reset();
        chk("abort_busy", bus.cfg_busy, 0);
        rd(3'd0, 5'd0, 8'd1, "sw0_restored");
        rd(3'd0, 5'd5, 8'd6, "sw5_restored");
        rd(3'd1, 5'd0, 8'd176, "bne0_restored");
        bus.cfg_start = 1'b1;
        bus.cfg_type  = 3'd0;
        tick();
        bus.cfg_start = 1'b0;
        chk("restart_busy", bus.cfg_busy, 1);
        do_reset();
`else
        // ROM build: loader port is inert.
        begin
            int ready_seen;
            int busy_seen;
            int done_seen;
            ready_seen = 0;
            busy_seen  = 0;
            done_seen  = 0;
            bus.cfg_start = 1'b1;
            bus.cfg_type  = 3'd1;
            tick();
            bus.cfg_start = 1'b0;
            for (int k = 0; k < 40; k++) begin
                bus.cfg_valid = 1'b1;
                bus.cfg_data  = 8'h20 + 8'(k);
                #1;
                if (bus.cfg_ready) ready_seen++;
                if (bus.cfg_busy) busy_seen++;
                if (bus.cfg_done) done_seen++;
                tick();
            end
            bus.cfg_valid = 1'b0;
            chk("rom_ready", ready_seen, 0);
            chk("rom_busy", busy_seen, 0);
            chk("rom_done", done_seen, 0);
        end
        rd(3'd1, 5'd0, 8'd176, "rom_bne0");
        rd(3'd1, 5'd1, 8'd7,   "rom_bne1");
        rd(3'd0, 5'd0, 8'd1,   "rom_sw0");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
